// File: rtl/frogger_pkg.sv
// Shared Frogger constants: playfield geometry, car bus sizing and the
// collision FSM state encoding.
package frogger_pkg;

  localparam int POS_W       = 6;
  localparam int MAX_X       = 20;
  localparam int NUM_CARS    = 10;
  localparam int CAR_LEN     = 2;
  localparam int START_LIVES = 3;
  localparam int LIVES_W     = 2;

  localparam int                NUM_LANES    = 5;
  localparam logic [POS_W-1:0]  LANE_Y_FIRST = 6'd8;
  localparam logic [POS_W-1:0]  LANE_Y_LAST  = 6'd12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_HIT      = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_OVER     = 3'd4
  } coll_state_e;

endpackage

// File: rtl/tile_overlap.sv
// Wrap-aware overlap test of one car against the frog tile; the car covers
// X .. X+CAR_LEN-1 modulo MAX_X+1 on its own lane.
module tile_overlap #(
  parameter int POS_W   = frogger_pkg::POS_W,
  parameter int MAX_X   = frogger_pkg::MAX_X,
  parameter int CAR_LEN = frogger_pkg::CAR_LEN
) (
  input  logic [POS_W-1:0] i_Car_X,
  input  logic [POS_W-1:0] i_Car_Y,
  input  logic [POS_W-1:0] i_Frog_X,
  input  logic [POS_W-1:0] i_Frog_Y,
  output logic             o_Match
);
  import frogger_pkg::*;

  localparam logic [POS_W:0] WRAP_C = (POS_W+1)'(MAX_X + 1);
  localparam logic [POS_W:0] LEN_C  = (POS_W+1)'(CAR_LEN);

  logic [POS_W:0] frog_ext_s;
  logic [POS_W:0] car_ext_s;
  logic [POS_W:0] dist_s;

  // Distance from car head to frog, folded into 0..MAX_X.
  always_comb begin
    frog_ext_s = {1'b0, i_Frog_X};
    car_ext_s  = {1'b0, i_Car_X};
    if (i_Frog_X < i_Car_X) begin
      dist_s = frog_ext_s + WRAP_C - car_ext_s;
    end else begin
      dist_s = frog_ext_s - car_ext_s;
    end
    o_Match = (i_Car_Y == i_Frog_Y) && (dist_s < LEN_C);
  end

endmodule

// File: rtl/frog_collision_ctrl.sv
// Frame-tick collision scanner: walks the snapshotted car list one car per
// cycle, charges a life on a hit and runs the respawn handshake.
module frog_collision_ctrl #(
  parameter int NUM_CARS    = frogger_pkg::NUM_CARS,
  parameter int POS_W       = frogger_pkg::POS_W,
  parameter int MAX_X       = frogger_pkg::MAX_X,
  parameter int CAR_LEN     = frogger_pkg::CAR_LEN,
  parameter int START_LIVES = frogger_pkg::START_LIVES,
  parameter int LIVES_W     = frogger_pkg::LIVES_W
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic [NUM_CARS*POS_W-1:0] i_Car_X,
  input  logic [NUM_CARS*POS_W-1:0] i_Car_Y,
  input  logic [POS_W-1:0]          i_Frog_X,
  input  logic [POS_W-1:0]          i_Frog_Y,
  input  logic                      i_Scan_Start,
  input  logic                      i_Respawn_Ack,
  input  logic                      i_Restart,
  output logic                      o_Busy,
  output logic                      o_Hit,
  output logic                      o_Respawn,
  output logic [LIVES_W-1:0]        o_Lives,
  output logic                      o_Game_Over
);
  import frogger_pkg::*;

  localparam int                 IDX_W         = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX_C    = IDX_W'(NUM_CARS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE_C     = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ZERO_C    = IDX_W'(0);
  localparam logic [LIVES_W-1:0] LIVES_START_C = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE_C   = LIVES_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_ZERO_C  = LIVES_W'(0);
  localparam logic [POS_W-1:0]   POS_ZERO_C    = POS_W'(0);

  coll_state_e        state_r;
  logic [POS_W-1:0]   car_x_r [NUM_CARS];
  logic [POS_W-1:0]   car_y_r [NUM_CARS];
  logic [POS_W-1:0]   frog_x_r;
  logic [POS_W-1:0]   frog_y_r;
  logic [IDX_W-1:0]   idx_r;
  logic               busy_r;
  logic               hit_r;
  logic               respawn_r;
  logic               over_r;
  logic [LIVES_W-1:0] lives_r;

  logic [POS_W-1:0]   sel_x_s;
  logic [POS_W-1:0]   sel_y_s;
  logic [LIVES_W-1:0] lives_dec_s;
  logic               match_s;

  // Current scan candidate and saturating life decrement.
  always_comb begin
    sel_x_s = car_x_r[idx_r];
    sel_y_s = car_y_r[idx_r];
    if (lives_r == LIVES_ZERO_C) begin
      lives_dec_s = LIVES_ZERO_C;
    end else begin
      lives_dec_s = lives_r - LIVES_ONE_C;
    end
  end

  tile_overlap #(
    .POS_W   (POS_W),
    .MAX_X   (MAX_X),
    .CAR_LEN (CAR_LEN)
  ) u_tile_overlap (
    .i_Car_X  (sel_x_s),
    .i_Car_Y  (sel_y_s),
    .i_Frog_X (frog_x_r),
    .i_Frog_Y (frog_y_r),
    .o_Match  (match_s)
  );

  // Collision FSM with snapshot, index, lives and registered flags.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r   <= ST_IDLE;
      for (int i = 0; i < NUM_CARS; i++) begin
        car_x_r[i] <= POS_ZERO_C;
        car_y_r[i] <= POS_ZERO_C;
      end
      frog_x_r  <= POS_ZERO_C;
      frog_y_r  <= POS_ZERO_C;
      idx_r     <= IDX_ZERO_C;
      busy_r    <= 1'b0;
      hit_r     <= 1'b0;
      respawn_r <= 1'b0;
      over_r    <= 1'b0;
      lives_r   <= LIVES_START_C;
    end else if (i_Restart) begin
      state_r   <= ST_IDLE;
      idx_r     <= IDX_ZERO_C;
      busy_r    <= 1'b0;
      hit_r     <= 1'b0;
      respawn_r <= 1'b0;
      over_r    <= 1'b0;
      lives_r   <= LIVES_START_C;
    end else begin
      hit_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_Scan_Start) begin
            for (int i = 0; i < NUM_CARS; i++) begin
              car_x_r[i] <= i_Car_X[i*POS_W +: POS_W];
              car_y_r[i] <= i_Car_Y[i*POS_W +: POS_W];
            end
            frog_x_r <= i_Frog_X;
            frog_y_r <= i_Frog_Y;
            idx_r    <= IDX_ZERO_C;
            busy_r   <= 1'b1;
            state_r  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (match_s) begin
            hit_r   <= 1'b1;
            lives_r <= lives_dec_s;
            state_r <= ST_HIT;
          end else if (idx_r == LAST_IDX_C) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            idx_r <= idx_r + IDX_ONE_C;
          end
        end
        ST_HIT: begin
          // lives_r already holds the post-hit count here.
          if (lives_r == LIVES_ZERO_C) begin
            over_r    <= 1'b1;
            respawn_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= ST_OVER;
          end else begin
            respawn_r <= 1'b1;
            state_r   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (i_Respawn_Ack) begin
            respawn_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        ST_OVER: begin
          over_r    <= 1'b1;
          respawn_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          busy_r    <= 1'b0;
          respawn_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Busy      = busy_r;
  assign o_Hit       = hit_r;
  assign o_Respawn   = respawn_r;
  assign o_Lives     = lives_r;
  assign o_Game_Over = over_r;

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Directed bench for frog_collision_ctrl with a scan-result scoreboard and a
// tile-by-tile reference model of car coverage.
module tb_frog_collision_ctrl;

  localparam int NC  = 10;
  localparam int PW  = 6;
  localparam int MOD = 21;
  localparam int LEN = 2;

  typedef struct packed {
    logic       hit;
    logic [1:0] lives;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NC*PW-1:0] car_x_bus;
  logic [NC*PW-1:0] car_y_bus;
  logic [PW-1:0]    frog_x;
  logic [PW-1:0]    frog_y;
  logic             scan;
  logic             ack;
  logic             restart;
  logic             busy;
  logic             hit;
  logic             respawn;
  logic [1:0]       lives;
  logic             over;

  logic [PW-1:0] cx [NC];
  logic [PW-1:0] cy [NC];
  exp_t          sb_q [$];
  int            total;
  int            passed;
  int            hit_pulses;
  int            exp_lives;
  int            n;

  frog_collision_ctrl dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Car_X       (car_x_bus),
    .i_Car_Y       (car_y_bus),
    .i_Frog_X      (frog_x),
    .i_Frog_Y      (frog_y),
    .i_Scan_Start  (scan),
    .i_Respawn_Ack (ack),
    .i_Restart     (restart),
    .o_Busy        (busy),
    .o_Hit         (hit),
    .o_Respawn     (respawn),
    .o_Lives       (lives),
    .o_Game_Over   (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    car_x_bus = '0;
    car_y_bus = '0;
    for (int i = 0; i < NC; i++) begin
      car_x_bus[i*PW +: PW] = cx[i];
      car_y_bus[i*PW +: PW] = cy[i];
    end
  end

  always @(negedge clk) begin
    if (hit) hit_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic bit model_hit();
    for (int i = 0; i < NC; i++) begin
      for (int k = 0; k < LEN; k++) begin
        if (cy[i] == frog_y && ((int'(cx[i]) + k) % MOD) == int'(frog_y * 0 + frog_x))
          return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic set_lanes();
    for (int i = 0; i < NC; i++) begin
      cx[i] = PW'(12 + 4 * (i / 5));
      cy[i] = PW'(8 + (i % 5));
    end
  endtask

  // Push expectation, pulse a scan, wait for a hit or scan end, pop and compare.
  task automatic do_scan(input string tag, input int inject_at, output int cycles);
    exp_t e;
    exp_t got;
    int   cnt;
    e.hit = model_hit();
    if (e.hit && exp_lives > 0) exp_lives--;
    e.lives = 2'(exp_lives);
    sb_q.push_back(e);
    scan = 1'b1;
    tick();
    scan = 1'b0;
    cnt = 1;
    while (busy && !hit && cnt < 40) begin
      if (cnt == inject_at) scan = 1'b1;
      tick();
      scan = 1'b0;
      if (busy && !hit) cnt++;
    end
    chk({tag, "_done"}, 32'(cnt < 40), 32'd1);
    got.hit   = hit;
    got.lives = lives;
    e = sb_q.pop_front();
    chk({tag, "_hit"}, 32'(got.hit), 32'(e.hit));
    chk({tag, "_lives"}, 32'(got.lives), 32'(e.lives));
    cycles = cnt;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; hit_pulses = 0; exp_lives = 3;
    rst_n = 1'b0; scan = 1'b0; ack = 1'b0; restart = 1'b0;
    set_lanes();
    frog_x = 6'd5; frog_y = 6'd7;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_respawn", 32'(respawn), 32'd0);
    chk("rst_over", 32'(over), 32'd0);
    chk("rst_lives", 32'(lives), 32'd3);
    rst_n = 1'b1;
    tick();

    // No overlap, with a scan pulse injected while busy.
    do_scan("no_overlap", 3, n);
    chk("no_overlap_busy_cycles", 32'(n), 32'd10);
    chk("no_overlap_pulses", 32'(hit_pulses), 32'd0);
    tick(); tick(); tick();
    chk("busy_pulse_dropped", 32'(busy), 32'd0);

    // Direct hit on car 4.
    cx[4] = 6'd3; cy[4] = 6'd10; frog_x = 6'd4; frog_y = 6'd10;
    do_scan("direct", 0, n);
    tick();
    chk("direct_respawn", 32'(respawn), 32'd1);
    chk("direct_busy_wait", 32'(busy), 32'd1);
    tick(); tick(); tick();
    chk("direct_respawn_held", 32'(respawn), 32'd1);
    do_ack();
    chk("direct_respawn_drop", 32'(respawn), 32'd0);
    chk("direct_idle", 32'(busy), 32'd0);
    chk("direct_pulses", 32'(hit_pulses), 32'd1);

    // Wrap-around coverage: car at X=20 covers 20 and 0.
    set_lanes();
    cx[9] = 6'd20; cy[9] = 6'd12; frog_x = 6'd0; frog_y = 6'd12;
    do_scan("wrap_x0", 0, n);
    tick();
    do_ack();
    chk("wrap_x0_respawn_drop", 32'(respawn), 32'd0);
    frog_x = 6'd1;
    do_scan("wrap_x1", 0, n);

    // Third hit ends the game without a respawn request.
    frog_x = 6'd0;
    do_scan("third", 0, n);
    tick();
    chk("third_over", 32'(over), 32'd1);
    chk("third_no_respawn", 32'(respawn), 32'd0);
    chk("third_busy", 32'(busy), 32'd0);
    scan = 1'b1;
    tick();
    scan = 1'b0;
    chk("over_scan_ignored", 32'(busy), 32'd0);
    tick(); tick();
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_sticky", 32'(over), 32'd1);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    exp_lives = 3;
    chk("restart_over_lives", 32'(lives), 32'd3);
    chk("restart_over_flag", 32'(over), 32'd0);
    chk("restart_over_busy", 32'(busy), 32'd0);

    // Restart together with ack during WAIT_ACK.
    do_scan("pre_restart", 0, n);
    tick();
    chk("wait_respawn", 32'(respawn), 32'd1);
    restart = 1'b1; ack = 1'b1;
    tick();
    restart = 1'b0; ack = 1'b0;
    exp_lives = 3;
    chk("restart_wait_lives", 32'(lives), 32'd3);
    chk("restart_wait_respawn", 32'(respawn), 32'd0);
    chk("restart_wait_busy", 32'(busy), 32'd0);

    // Lose a life, then reset asynchronously mid-scan.
    do_scan("pre_reset", 0, n);
    tick();
    do_ack();
    frog_x = 6'd5; frog_y = 6'd7;
    scan = 1'b1;
    tick();
    scan = 1'b0;
    tick(); tick(); tick();
    chk("mid_scan_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_lives = 3;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_lives", 32'(lives), 32'd3);
    chk("async_rst_respawn", 32'(respawn), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_scan("post_reset", 0, n);
    chk("post_reset_cycles", 32'(n), 32'd10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
